fsm_slave_resp: RTL and testbench

Slave-side responder for the two-master crossbar: the target end of the req/cmd/addr/wdata → ack/rdata protocol driven by the master FSMs. It arbitrates between the two master request ports and services the granted request against a local register-file memory. It returns a one-cycle ack and holds read data long enough for the master's post-ack capture cycle. One instance sits behind each crossbar slave port.

---
 rtl/crossbar_pkg.sv | 22 ++
 rtl/reg_ena.sv | 20 ++
 rtl/rr_arb2.sv | 43 ++++
 rtl/fsm_slave_resp.sv | 161 ++++++++++++++++
 tb/tb_fsm_slave_resp.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/crossbar_pkg.sv
// Shared definitions for the two-master crossbar: FSM state encoding,
// command codes and master indices.
package crossbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  function automatic logic onehot_to_idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/reg_ena.sv
// Generic enabled register with synchronous active-high reset to zero.
module reg_ena #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-request arbiter with one-hot grant. SLAVE_RR_ARB_EN selects round-robin
// tie-break; otherwise fixed priority to request 0 with no state at all.
module rr_arb2 (
`ifdef SLAVE_RR_ARB_EN
  input  logic       clock,
  input  logic       reset,
  input  logic       update,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef SLAVE_RR_ARB_EN
  import crossbar_pkg::*;

  logic last_q, last_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= M2;
    end else begin
      last_q <= last_d;
    end
  end

  // On a tie the master that was not served last wins.
  always_comb begin
    grant  = req;
    last_d = last_q;
    if (req == 2'b11) begin
      grant = (last_q == M2) ? 2'b01 : 2'b10;
    end
    if (update && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end
`else
  always_comb begin
    grant = req[0] ? 2'b01 : {req[1], 1'b0};
  end
`endif

endmodule

// File: rtl/fsm_slave_resp.sv
// Crossbar slave responder: arbitrates two masters and services the winner
// against a local register file. Tie-break mode set by SLAVE_RR_ARB_EN.
module fsm_slave_resp
  import crossbar_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_1m,
  input  logic                  req_2m,
  input  logic                  cmd_1m,
  input  logic                  cmd_2m,
  input  logic [ADDR_WIDTH-1:0] addr_1m,
  input  logic [ADDR_WIDTH-1:0] addr_2m,
  input  logic [DATA_WIDTH-1:0] wdata_1m,
  input  logic [DATA_WIDTH-1:0] wdata_2m,
  output logic                  ack_1m,
  output logic                  ack_2m,
  output logic [DATA_WIDTH-1:0] rdata_1m,
  output logic [DATA_WIDTH-1:0] rdata_2m
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam int DEPTH = 2 ** IDX_W;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    cmd_q, cmd_d;
  logic [IDX_W-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [1:0]              arb_grant;
  logic                    commit;
  logic                    mem_we;
  logic                    rd_en_1m, rd_en_2m;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    unused_addr_msb;

  assign unused_addr_msb = addr_1m[ADDR_WIDTH-1] ^ addr_2m[ADDR_WIDTH-1];

`ifdef SLAVE_RR_ARB_EN
  logic arb_update;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .update (arb_update),
    .req    ({req_2m, req_1m}),
    .grant  (arb_grant)
  );
`else
  rr_arb2 u_arb (
    .req    ({req_2m, req_1m}),
    .grant  (arb_grant)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= M2;
      cmd_q   <= CMD_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    commit     = 1'b0;
`ifdef SLAVE_RR_ARB_EN
    arb_update = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_grant != 2'b00) begin
`ifdef SLAVE_RR_ARB_EN
          arb_update = 1'b1;
`endif
          grant_d = onehot_to_idx(arb_grant);
          if (arb_grant[0]) begin
            cmd_d   = cmd_1m;
            addr_d  = addr_1m[IDX_W-1:0];
            wdata_d = wdata_1m;
          end else begin
            cmd_d   = cmd_2m;
            addr_d  = addr_2m[IDX_W-1:0];
            wdata_d = wdata_2m;
          end
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we   = commit && (cmd_q == CMD_WRITE);
  assign rd_en_1m = commit && (cmd_q == CMD_READ) && (grant_q == M1);
  assign rd_en_2m = commit && (cmd_q == CMD_READ) && (grant_q == M2);
  assign rd_word  = mem_q[addr_q];

  // Reset clears every word so a write caught mid-access leaves no trace.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  reg_ena #(.WIDTH(DATA_WIDTH)) u_rdata_1m (
    .clock (clock),
    .reset (reset),
    .ena   (rd_en_1m),
    .d     (rd_word),
    .q     (rdata_1m)
  );

  reg_ena #(.WIDTH(DATA_WIDTH)) u_rdata_2m (
    .clock (clock),
    .reset (reset),
    .ena   (rd_en_2m),
    .d     (rd_word),
    .q     (rdata_2m)
  );

  assign ack_1m = (state_q == ST_ACK) && (grant_q == M1);
  assign ack_2m = (state_q == ST_ACK) && (grant_q == M2);

endmodule

// File: tb/tb_fsm_slave_resp.sv
// Scoreboard bench for fsm_slave_resp: a transaction-level model predicts
// service order, ack cycle and read data; a monitor checks each ack.
module tb_fsm_slave_resp;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int W     = 1;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_1m = 1'b0, req_2m = 1'b0;
  logic          cmd_1m = 1'b0, cmd_2m = 1'b0;
  logic [AW-1:0] addr_1m = '0, addr_2m = '0;
  logic [DW-1:0] wdata_1m = '0, wdata_2m = '0;
  logic          ack_1m, ack_2m;
  logic [DW-1:0] rdata_1m, rdata_2m;

  fsm_slave_resp #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_1m   (req_1m),
    .req_2m   (req_2m),
    .cmd_1m   (cmd_1m),
    .cmd_2m   (cmd_2m),
    .addr_1m  (addr_1m),
    .addr_2m  (addr_2m),
    .wdata_1m (wdata_1m),
    .wdata_2m (wdata_2m),
    .ack_1m   (ack_1m),
    .ack_2m   (ack_2m),
    .rdata_1m (rdata_1m),
    .rdata_2m (rdata_2m)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          master;
    bit          is_read;
    logic [31:0] data;
    int          ack_cyc;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  int          last_served = 2;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    last_served = 2;
  endtask

  task automatic modelServe(input int m, input bit cmd, input logic [3:0] a,
                            input logic [31:0] d, input int ack_cyc);
    txn_t t;
    int   idx;
    idx       = int'(a) % DEPTH;
    t.master  = m;
    t.is_read = (cmd == 1'b0);
    t.data    = cmd ? 32'h0 : model_mem[idx];
    t.ack_cyc = ack_cyc;
    if (cmd) model_mem[idx] = d;
    last_served = m;
    sb.push_back(t);
  endtask

  task automatic applyStimulus(input bit r1, input bit r2, input bit c1, input bit c2,
                               input logic [3:0] a1, input logic [3:0] a2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input bit hold_extra);
    int first, second, c, drop1, drop2;
    bit p1, p2;
    @(negedge clock);
    c = cyc;
    if (r1 && r2) begin
`ifdef SLAVE_RR_ARB_EN
      first = (last_served == 2) ? 1 : 2;
`else
      first = 1;
`endif
      second = 3 - first;
    end else begin
      first  = r1 ? 1 : 2;
      second = 0;
    end
    if (first == 1) modelServe(1, c1, a1, d1, c + W + 2);
    else            modelServe(2, c2, a2, d2, c + W + 2);
    if (second == 1) modelServe(1, c1, a1, d1, c + (W + 4) + W + 2);
    if (second == 2) modelServe(2, c2, a2, d2, c + (W + 4) + W + 2);

    req_1m = r1; cmd_1m = c1; addr_1m = a1; wdata_1m = d1;
    req_2m = r2; cmd_2m = c2; addr_2m = a2; wdata_2m = d2;
    p1 = r1; p2 = r2; drop1 = -1; drop2 = -1;
    for (int k = 0; k < 200 && (p1 || p2 || drop1 >= 0 || drop2 >= 0); k++) begin
      @(negedge clock);
      if (drop1 >= 0 && cyc >= drop1) begin req_1m = 1'b0; drop1 = -1; end
      if (drop2 >= 0 && cyc >= drop2) begin req_2m = 1'b0; drop2 = -1; end
      if (p1 && ack_1m) begin
        p1 = 1'b0;
        if (hold_extra) drop1 = cyc + 1; else req_1m = 1'b0;
      end
      if (p2 && ack_2m) begin
        p2 = 1'b0;
        if (hold_extra) drop2 = cyc + 1; else req_2m = 1'b0;
      end
    end
    if (p1 || p2) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ack_timeout: pending m1=%0b m2=%0b, want none", p1, p2);
    end
    req_1m = 1'b0;
    req_2m = 1'b0;
    repeat (2 + $urandom_range(0, 2)) @(negedge clock);
  endtask

  // Monitor: pops one expectation per ack and tracks the rdata each master should see.
  initial begin : monitor
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    txn_t        t;
    exp_rd1 = '0;
    exp_rd2 = '0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        sb.delete();
        exp_rd1 = '0;
        exp_rd2 = '0;
      end else begin
        if (ack_1m || ack_2m) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_ack: got ack_1m=%0b ack_2m=%0b at cycle %0d, want no ack",
                     ack_1m, ack_2m, cyc);
          end else begin
            t = sb.pop_front();
            checkOutput("ack_master", {30'h0, ack_2m, ack_1m}, (t.master == 1) ? 32'h1 : 32'h2);
            checkOutput("ack_cycle", cyc, t.ack_cyc);
            if (t.is_read) begin
              if (t.master == 1) exp_rd1 = t.data;
              else               exp_rd2 = t.data;
            end
          end
        end
        checkOutput("rdata_1m", rdata_1m, exp_rd1);
        checkOutput("rdata_2m", rdata_2m, exp_rd2);
      end
    end
  end

  initial begin : stimulus
    bit          r1, r2;
    modelReset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_ack_1m", {31'h0, ack_1m}, 32'h0);
    checkOutput("reset_ack_2m", {31'h0, ack_2m}, 32'h0);
    checkOutput("reset_rdata_1m", rdata_1m, 32'h0);
    checkOutput("reset_rdata_2m", rdata_2m, 32'h0);

    $display("[TB] directed transactions");
    applyStimulus(1, 0, 0, 0, 4'h3, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, 1, 0, 4'h2, 4'h0, 32'hDEADBEEF, 32'h0, 0);
    applyStimulus(1, 0, 0, 0, 4'h2, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus(0, 1, 0, 1, 4'h0, 4'hA, 32'h0, 32'h12345678, 0);
    applyStimulus(1, 0, 0, 0, 4'h2, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus(1, 1, 0, 0, 4'h2, 4'h5, 32'h0, 32'h0, 0);
    applyStimulus(1, 1, 0, 0, 4'h3, 4'h2, 32'h0, 32'h0, 1);

    $display("[TB] reset during write access");
    @(negedge clock);
    req_2m = 1'b1; cmd_2m = 1'b1; addr_2m = 4'h1; wdata_2m = 32'hCAFEF00D;
    @(negedge clock);
    reset = 1'b1;
    req_2m = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    modelReset();
    @(negedge clock);
    checkOutput("midreset_ack_1m", {31'h0, ack_1m}, 32'h0);
    checkOutput("midreset_ack_2m", {31'h0, ack_2m}, 32'h0);
    checkOutput("midreset_rdata_1m", rdata_1m, 32'h0);
    checkOutput("midreset_rdata_2m", rdata_2m, 32'h0);
    applyStimulus(1, 0, 0, 0, 4'h1, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus(1, 1, 0, 0, 4'h2, 4'h3, 32'h0, 32'h0, 0);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      if (!r1 && !r2) r1 = 1'b1;
      applyStimulus(r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    $urandom, $urandom, ($urandom_range(0, 3) == 0));
    end

    repeat (6) @(negedge clock);
    checkOutput("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
